// File: rtl/data_mem_interface_pkg.sv
// Shared definitions for the data-memory interface and the cache that drives it:
// state encodings, cache command codes and default widths.
package data_mem_interface_pkg;

  localparam int unsigned DEF_DATA_WIDTH     = 16;
  localparam int unsigned DEF_CACHE_DEPTH    = 16;
  localparam int unsigned DEF_DDR_ADDR_WIDTH = 28;
  localparam int unsigned DEF_MEM_DATA_WIDTH = 32;
  localparam int unsigned LEN_WIDTH          = 10;
  localparam int unsigned STATE_WIDTH        = 4;

  // The cache decodes state_interface_module, so these values are fixed.
  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE                 = 4'd0,
    MEM_READ_DATA        = 4'd1,
    MEM_READ_JMP         = 4'd2,
    MEM_READ_END         = 4'd3,
    MEM_WRITE_DATA_STORE = 4'd9,
    MEM_WRITE_END        = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE      = 2'd0,
    CMD_DATA_READ = 2'd1,
    CMD_JMP_READ  = 2'd2,
    CMD_STORE     = 2'd3
  } cache_cmd_e;

  // Fixed priority: store, then data read, then jump read.
  function automatic cache_cmd_e pick_cmd(input logic store, input logic rd, input logic jmp);
    if (store)    return CMD_STORE;
    else if (rd)  return CMD_DATA_READ;
    else if (jmp) return CMD_JMP_READ;
    else          return CMD_NONE;
  endfunction

endpackage

// File: rtl/data_mem_interface_if.sv
// Cache-side and memory-side bus of the data-memory interface.
// master = the interface block, slave = cache/memory environment.
interface data_mem_interface_if import data_mem_interface_pkg::*; #(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned DDR_ADDR_WIDTH = DEF_DDR_ADDR_WIDTH,
  parameter int unsigned MEM_DATA_WIDTH = DEF_MEM_DATA_WIDTH
) ();

  logic                      DATA_read_req;
  logic [DDR_ADDR_WIDTH-1:0] DATA_read_addr;
  logic                      JMP_ADDR_read_req;
  logic                      DATA_store_req;
  logic [DDR_ADDR_WIDTH-1:0] DATA_write_addr;
  logic [DATA_WIDTH-1:0]     DATA_to_ddr;
  logic                      data_to_ddr_rdy;

  logic [DATA_WIDTH-1:0]     DATA_to_cache;
  logic [DDR_ADDR_WIDTH-1:0] JMP_ADDR_to_cache;
  logic [LEN_WIDTH-1:0]      rd_cnt_data;
  logic                      rd_burst_data_valid;
  logic                      wr_burst_data_req;
  logic [STATE_WIDTH-1:0]    state_interface_module;

  logic                      mem_rd_req;
  logic [DDR_ADDR_WIDTH-1:0] mem_rd_addr;
  logic [LEN_WIDTH-1:0]      mem_rd_len;
  logic [MEM_DATA_WIDTH-1:0] mem_rd_data;
  logic                      mem_rd_valid;
  logic                      mem_rd_finish;

  logic                      mem_wr_req;
  logic [DDR_ADDR_WIDTH-1:0] mem_wr_addr;
  logic [LEN_WIDTH-1:0]      mem_wr_len;
  logic [MEM_DATA_WIDTH-1:0] mem_wr_data;
  logic                      mem_wr_data_req;
  logic                      mem_wr_finish;

  modport master (
    input  DATA_read_req, DATA_read_addr, JMP_ADDR_read_req, DATA_store_req,
           DATA_write_addr, DATA_to_ddr, data_to_ddr_rdy,
           mem_rd_data, mem_rd_valid, mem_rd_finish, mem_wr_data_req, mem_wr_finish,
    output DATA_to_cache, JMP_ADDR_to_cache, rd_cnt_data, rd_burst_data_valid,
           wr_burst_data_req, state_interface_module,
           mem_rd_req, mem_rd_addr, mem_rd_len, mem_wr_req, mem_wr_addr, mem_wr_len, mem_wr_data
  );

  modport slave (
    output DATA_read_req, DATA_read_addr, JMP_ADDR_read_req, DATA_store_req,
           DATA_write_addr, DATA_to_ddr, data_to_ddr_rdy,
           mem_rd_data, mem_rd_valid, mem_rd_finish, mem_wr_data_req, mem_wr_finish,
    input  DATA_to_cache, JMP_ADDR_to_cache, rd_cnt_data, rd_burst_data_valid,
           wr_burst_data_req, state_interface_module,
           mem_rd_req, mem_rd_addr, mem_rd_len, mem_wr_req, mem_wr_addr, mem_wr_len, mem_wr_data
  );

endinterface

// File: rtl/data_mem_interface_req_edge_arm.sv
// Arms on a rising edge of i_req and disarms on i_clr (grant), so a level
// held high after its burst never re-triggers.
module req_edge_arm (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_clr,
  output logic o_armed
);

  logic r_req_d;
  logic r_armed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_d <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_req_d <= i_req;
      if (i_clr)
        r_armed <= 1'b0;
      else if (i_req && !r_req_d)
        r_armed <= 1'b1;
    end
  end

  assign o_armed = r_armed;

endmodule

// File: rtl/data_mem_interface.sv
// Sequences cache data reads, jump-address reads and stores onto the
// burst memory port.
//   state                | meaning
//   IDLE                 | waiting for an armed request
//   MEM_READ_DATA        | data burst read, DATA_CACHE_DEPTH+1 beats
//   MEM_READ_JMP         | single-beat jump-address read
//   MEM_READ_END         | one cycle after read finish
//   MEM_WRITE_DATA_STORE | store burst, DATA_CACHE_DEPTH beats
//   MEM_WRITE_END        | one cycle after write finish
module data_mem_interface import data_mem_interface_pkg::*; #(
  parameter int unsigned DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int unsigned DATA_CACHE_DEPTH = DEF_CACHE_DEPTH,
  parameter int unsigned DDR_ADDR_WIDTH   = DEF_DDR_ADDR_WIDTH,
  parameter int unsigned MEM_DATA_WIDTH   = DEF_MEM_DATA_WIDTH
) (
  input logic                  clk,
  input logic                  rst,
  data_mem_interface_if.master bus
);

  state_e     r_state;
  state_e     w_state_nxt;
  cache_cmd_e w_grant;

  logic w_armed_store;
  logic w_armed_rd;
  logic w_armed_jmp;
  logic w_in_read;
  logic w_beat_accept;
  logic w_wr_burst_req;

  logic                      r_mem_rd_req;
  logic                      r_mem_wr_req;
  logic [DDR_ADDR_WIDTH-1:0] r_mem_rd_addr;
  logic [DDR_ADDR_WIDTH-1:0] r_mem_wr_addr;
  logic [DDR_ADDR_WIDTH-1:0] r_jmp_addr;
  logic [LEN_WIDTH-1:0]      r_mem_rd_len;
  logic [LEN_WIDTH-1:0]      r_mem_wr_len;
  logic [LEN_WIDTH-1:0]      r_rd_cnt;
  logic [LEN_WIDTH-1:0]      r_wr_cnt;
  logic                      r_rd_valid;
  logic [DATA_WIDTH-1:0]     r_data_to_cache;

  req_edge_arm u_arm_store (
    .clk(clk), .rst(rst), .i_req(bus.DATA_store_req),
    .i_clr(w_grant == CMD_STORE), .o_armed(w_armed_store)
  );

  req_edge_arm u_arm_rd (
    .clk(clk), .rst(rst), .i_req(bus.DATA_read_req),
    .i_clr(w_grant == CMD_DATA_READ), .o_armed(w_armed_rd)
  );

  req_edge_arm u_arm_jmp (
    .clk(clk), .rst(rst), .i_req(bus.JMP_ADDR_read_req),
    .i_clr(w_grant == CMD_JMP_READ), .o_armed(w_armed_jmp)
  );

  assign w_in_read      = (r_state == MEM_READ_DATA) || (r_state == MEM_READ_JMP);
  // Beats beyond mem_rd_len are dropped so the count saturates.
  assign w_beat_accept  = w_in_read && bus.mem_rd_valid && (r_rd_cnt < r_mem_rd_len);
  assign w_wr_burst_req = (r_state == MEM_WRITE_DATA_STORE) && bus.mem_wr_data_req &&
                          (r_wr_cnt < LEN_WIDTH'(DATA_CACHE_DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = CMD_NONE;
    case (r_state)
      IDLE: begin
        w_grant = pick_cmd(w_armed_store, w_armed_rd, w_armed_jmp);
        case (w_grant)
          CMD_STORE:     w_state_nxt = MEM_WRITE_DATA_STORE;
          CMD_DATA_READ: w_state_nxt = MEM_READ_DATA;
          CMD_JMP_READ:  w_state_nxt = MEM_READ_JMP;
          default:       w_state_nxt = IDLE;
        endcase
      end
      MEM_READ_DATA, MEM_READ_JMP:
        if (bus.mem_rd_finish) w_state_nxt = MEM_READ_END;
      MEM_READ_END:
        w_state_nxt = IDLE;
      MEM_WRITE_DATA_STORE:
        if (bus.mem_wr_finish) w_state_nxt = MEM_WRITE_END;
      MEM_WRITE_END:
        w_state_nxt = IDLE;
      default:
        w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_rd_req    <= 1'b0;
      r_mem_wr_req    <= 1'b0;
      r_mem_rd_addr   <= '0;
      r_mem_wr_addr   <= '0;
      r_jmp_addr      <= '0;
      r_mem_rd_len    <= '0;
      r_mem_wr_len    <= '0;
      r_rd_cnt        <= '0;
      r_wr_cnt        <= '0;
      r_rd_valid      <= 1'b0;
      r_data_to_cache <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      if (w_grant != CMD_NONE) begin
        r_rd_cnt <= '0;
        r_wr_cnt <= '0;
      end
      case (w_grant)
        CMD_STORE: begin
          r_mem_wr_req  <= 1'b1;
          r_mem_wr_addr <= bus.DATA_write_addr;
          r_mem_wr_len  <= LEN_WIDTH'(DATA_CACHE_DEPTH);
        end
        CMD_DATA_READ: begin
          // One extra beat covers the cache's capture delay.
          r_mem_rd_req  <= 1'b1;
          r_mem_rd_addr <= bus.DATA_read_addr;
          r_mem_rd_len  <= LEN_WIDTH'(DATA_CACHE_DEPTH + 1);
        end
        CMD_JMP_READ: begin
          r_mem_rd_req  <= 1'b1;
          r_mem_rd_addr <= bus.DATA_read_addr;
          r_mem_rd_len  <= LEN_WIDTH'(1);
        end
        default: ;
      endcase
      if (w_in_read && bus.mem_rd_finish)
        r_mem_rd_req <= 1'b0;
      if ((r_state == MEM_WRITE_DATA_STORE) && bus.mem_wr_finish)
        r_mem_wr_req <= 1'b0;
      if (w_beat_accept) begin
        r_rd_valid      <= 1'b1;
        r_rd_cnt        <= r_rd_cnt + LEN_WIDTH'(1);
        r_data_to_cache <= bus.mem_rd_data[DATA_WIDTH-1:0];
        if (r_state == MEM_READ_JMP)
          r_jmp_addr <= bus.mem_rd_data[DDR_ADDR_WIDTH-1:0];
      end
      if (w_wr_burst_req && bus.data_to_ddr_rdy)
        r_wr_cnt <= r_wr_cnt + LEN_WIDTH'(1);
    end
  end

  assign bus.state_interface_module = r_state;
  assign bus.DATA_to_cache          = r_data_to_cache;
  assign bus.JMP_ADDR_to_cache      = r_jmp_addr;
  assign bus.rd_cnt_data            = r_rd_cnt;
  assign bus.rd_burst_data_valid    = r_rd_valid;
  assign bus.wr_burst_data_req      = w_wr_burst_req;
  assign bus.mem_rd_req             = r_mem_rd_req;
  assign bus.mem_rd_addr            = r_mem_rd_addr;
  assign bus.mem_rd_len             = r_mem_rd_len;
  assign bus.mem_wr_req             = r_mem_wr_req;
  assign bus.mem_wr_addr            = r_mem_wr_addr;
  assign bus.mem_wr_len             = r_mem_wr_len;
  assign bus.mem_wr_data            = bus.data_to_ddr_rdy ? MEM_DATA_WIDTH'(bus.DATA_to_ddr) : '0;

endmodule

// File: tb/tb_data_mem_interface.sv
// Directed self-checking bench for data_mem_interface: table-driven arbitration
// and write-data vectors plus hand-written burst sequences.
module tb_data_mem_interface;
  import data_mem_interface_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  data_mem_interface_if #(.DATA_WIDTH(16), .DDR_ADDR_WIDTH(28), .MEM_DATA_WIDTH(32)) bus ();

  data_mem_interface #(
    .DATA_WIDTH(16), .DATA_CACHE_DEPTH(16), .DDR_ADDR_WIDTH(28), .MEM_DATA_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct packed {
    logic       store;
    logic       rd;
    logic       jmp;
    logic [3:0] exp_state;
    logic       exp_rd_req;
    logic       exp_wr_req;
    logic [9:0] exp_len;
  } arb_vec_t;

  typedef struct packed {
    logic        rdy;
    logic [15:0] data;
    logic [31:0] exp;
  } wd_vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.DATA_read_req     = 1'b0;
    bus.DATA_read_addr    = '0;
    bus.JMP_ADDR_read_req = 1'b0;
    bus.DATA_store_req    = 1'b0;
    bus.DATA_write_addr   = '0;
    bus.DATA_to_ddr       = '0;
    bus.data_to_ddr_rdy   = 1'b0;
    bus.mem_rd_data       = '0;
    bus.mem_rd_valid      = 1'b0;
    bus.mem_rd_finish     = 1'b0;
    bus.mem_wr_data_req   = 1'b0;
    bus.mem_wr_finish     = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " state"},     32'(bus.state_interface_module), 32'd0);
    check({tag, " rd_req"},    32'(bus.mem_rd_req), 32'd0);
    check({tag, " wr_req"},    32'(bus.mem_wr_req), 32'd0);
    check({tag, " rd_cnt"},    32'(bus.rd_cnt_data), 32'd0);
    check({tag, " rd_valid"},  32'(bus.rd_burst_data_valid), 32'd0);
    check({tag, " wr_burst"},  32'(bus.wr_burst_data_req), 32'd0);
    check({tag, " to_cache"},  32'(bus.DATA_to_cache), 32'd0);
    check({tag, " jmp_addr"},  32'(bus.JMP_ADDR_to_cache), 32'd0);
    check({tag, " rd_addr"},   32'(bus.mem_rd_addr), 32'd0);
    check({tag, " wr_addr"},   32'(bus.mem_wr_addr), 32'd0);
    check({tag, " rd_len"},    32'(bus.mem_rd_len), 32'd0);
    check({tag, " wr_len"},    32'(bus.mem_wr_len), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    arb_vec_t arb[7];
    wd_vec_t  wd[4];
    int       pulses;
    int       grants;
    logic [3:0] cur;
    logic [3:0] prev;

    arb[0] = '{1'b1, 1'b0, 1'b0, 4'd9, 1'b0, 1'b1, 10'd16};
    arb[1] = '{1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 10'd17};
    arb[2] = '{1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 10'd1};
    arb[3] = '{1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 10'd16};
    arb[4] = '{1'b1, 1'b0, 1'b1, 4'd9, 1'b0, 1'b1, 10'd16};
    arb[5] = '{1'b0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 10'd17};
    arb[6] = '{1'b1, 1'b1, 1'b1, 4'd9, 1'b0, 1'b1, 10'd16};

    wd[0] = '{1'b1, 16'hBEEF, 32'h0000BEEF};
    wd[1] = '{1'b0, 16'hBEEF, 32'h00000000};
    wd[2] = '{1'b1, 16'hFFFF, 32'h0000FFFF};
    wd[3] = '{1'b1, 16'h0000, 32'h00000000};

    // Reset state while rst is held low.
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b1;
    tick();
    check("post_reset state", 32'(bus.state_interface_module), 32'd0);

    for (int i = 0; i < 4; i++) begin
      bus.data_to_ddr_rdy = wd[i].rdy;
      bus.DATA_to_ddr     = wd[i].data;
      #1;
      check($sformatf("wr_data_mux[%0d]", i), bus.mem_wr_data, wd[i].exp);
    end
    idle_inputs();

    // Arbitration priority table.
    for (int i = 0; i < 7; i++) begin
      apply_reset();
      bus.DATA_read_addr    = 28'h111;
      bus.DATA_write_addr   = 28'h222;
      bus.DATA_store_req    = arb[i].store;
      bus.DATA_read_req     = arb[i].rd;
      bus.JMP_ADDR_read_req = arb[i].jmp;
      tick();
      tick();
      check($sformatf("arb[%0d] state", i),  32'(bus.state_interface_module), 32'(arb[i].exp_state));
      check($sformatf("arb[%0d] rd_req", i), 32'(bus.mem_rd_req), 32'(arb[i].exp_rd_req));
      check($sformatf("arb[%0d] wr_req", i), 32'(bus.mem_wr_req), 32'(arb[i].exp_wr_req));
      if (arb[i].exp_wr_req) begin
        check($sformatf("arb[%0d] wr_len", i),  32'(bus.mem_wr_len), 32'(arb[i].exp_len));
        check($sformatf("arb[%0d] wr_addr", i), 32'(bus.mem_wr_addr), 32'h222);
      end else begin
        check($sformatf("arb[%0d] rd_len", i),  32'(bus.mem_rd_len), 32'(arb[i].exp_len));
        check($sformatf("arb[%0d] rd_addr", i), 32'(bus.mem_rd_addr), 32'h111);
      end
    end

    // Data read burst of 17 beats.
    apply_reset();
    bus.DATA_read_addr = 28'h280;
    bus.DATA_read_req  = 1'b1;
    tick();
    tick();
    check("rd state", 32'(bus.state_interface_module), 32'd1);
    check("rd len", 32'(bus.mem_rd_len), 32'd17);
    check("rd addr", 32'(bus.mem_rd_addr), 32'h280);
    check("rd req", 32'(bus.mem_rd_req), 32'd1);
    check("rd cnt start", 32'(bus.rd_cnt_data), 32'd0);
    pulses = 0;
    for (int i = 0; i < 17; i++) begin
      bus.mem_rd_data  = 32'h1000 + 32'(i);
      bus.mem_rd_valid = 1'b1;
      tick();
      if (bus.rd_burst_data_valid === 1'b1) pulses++;
      check($sformatf("rd beat%0d cnt", i + 1), 32'(bus.rd_cnt_data), 32'(i + 1));
      check($sformatf("rd beat%0d data", i + 1), 32'(bus.DATA_to_cache), 32'h1000 + 32'(i));
    end
    bus.mem_rd_valid  = 1'b0;
    bus.mem_rd_finish = 1'b1;
    tick();
    check("rd pulses", 32'(pulses), 32'd17);
    check("rd end state", 32'(bus.state_interface_module), 32'd3);
    check("rd end req", 32'(bus.mem_rd_req), 32'd0);
    check("rd end valid", 32'(bus.rd_burst_data_valid), 32'd0);
    bus.mem_rd_finish = 1'b0;
    tick();
    check("rd idle state", 32'(bus.state_interface_module), 32'd0);
    check("rd hold cnt", 32'(bus.rd_cnt_data), 32'd17);
    check("rd last data", 32'(bus.DATA_to_cache), 32'h1010);
    check("rd idle valid", 32'(bus.rd_burst_data_valid), 32'd0);
    bus.DATA_read_req = 1'b0;

    // Jump read, including an extra beat that must be ignored.
    apply_reset();
    bus.DATA_read_addr    = 28'h300;
    bus.JMP_ADDR_read_req = 1'b1;
    tick();
    tick();
    check("jmp state", 32'(bus.state_interface_module), 32'd2);
    check("jmp len", 32'(bus.mem_rd_len), 32'd1);
    bus.mem_rd_data  = 32'h00ABCDEF;
    bus.mem_rd_valid = 1'b1;
    tick();
    check("jmp addr", 32'(bus.JMP_ADDR_to_cache), 32'h0ABCDEF);
    check("jmp cnt", 32'(bus.rd_cnt_data), 32'd1);
    check("jmp valid", 32'(bus.rd_burst_data_valid), 32'd1);
    check("jmp to_cache", 32'(bus.DATA_to_cache), 32'hCDEF);
    bus.mem_rd_data = 32'h00123456;
    tick();
    check("jmp sat cnt", 32'(bus.rd_cnt_data), 32'd1);
    check("jmp sat valid", 32'(bus.rd_burst_data_valid), 32'd0);
    check("jmp sat addr", 32'(bus.JMP_ADDR_to_cache), 32'h0ABCDEF);
    bus.mem_rd_valid  = 1'b0;
    bus.mem_rd_finish = 1'b1;
    tick();
    check("jmp end state", 32'(bus.state_interface_module), 32'd3);
    bus.mem_rd_finish = 1'b0;
    tick();
    check("jmp idle state", 32'(bus.state_interface_module), 32'd0);
    check("jmp hold addr", 32'(bus.JMP_ADDR_to_cache), 32'h0ABCDEF);
    check("jmp hold cnt", 32'(bus.rd_cnt_data), 32'd1);
    bus.JMP_ADDR_read_req = 1'b0;

    // Store burst: 20 data requests, only 16 forwarded.
    apply_reset();
    bus.DATA_write_addr = 28'h400;
    bus.DATA_store_req  = 1'b1;
    tick();
    tick();
    check("st state", 32'(bus.state_interface_module), 32'd9);
    check("st len", 32'(bus.mem_wr_len), 32'd16);
    check("st addr", 32'(bus.mem_wr_addr), 32'h400);
    check("st req", 32'(bus.mem_wr_req), 32'd1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      bus.data_to_ddr_rdy = 1'b1;
      bus.DATA_to_ddr     = 16'h0A00 + 16'(i);
      bus.mem_wr_data_req = 1'b1;
      #1;
      if (bus.wr_burst_data_req === 1'b1) pulses++;
      check($sformatf("st wr_burst[%0d]", i), 32'(bus.wr_burst_data_req), (i < 16) ? 32'd1 : 32'd0);
      check($sformatf("st wr_data[%0d]", i), bus.mem_wr_data, 32'h0A00 + 32'(i));
      tick();
      check($sformatf("st state[%0d]", i), 32'(bus.state_interface_module), 32'd9);
    end
    check("st pulses", 32'(pulses), 32'd16);
    bus.mem_wr_data_req = 1'b0;
    bus.mem_wr_finish   = 1'b1;
    tick();
    check("st end state", 32'(bus.state_interface_module), 32'd10);
    check("st end req", 32'(bus.mem_wr_req), 32'd0);
    bus.mem_wr_finish = 1'b0;
    tick();
    check("st idle state", 32'(bus.state_interface_module), 32'd0);
    bus.DATA_store_req = 1'b0;
    idle_inputs();

    // Store and read rising together: store first, then read.
    apply_reset();
    bus.DATA_write_addr = 28'h500;
    bus.DATA_read_addr  = 28'h600;
    bus.DATA_store_req  = 1'b1;
    bus.DATA_read_req   = 1'b1;
    tick();
    tick();
    check("both st state", 32'(bus.state_interface_module), 32'd9);
    check("both st rd_req", 32'(bus.mem_rd_req), 32'd0);
    check("both st addr", 32'(bus.mem_wr_addr), 32'h500);
    bus.mem_wr_finish = 1'b1;
    tick();
    bus.mem_wr_finish = 1'b0;
    check("both wr_end", 32'(bus.state_interface_module), 32'd10);
    tick();
    check("both idle", 32'(bus.state_interface_module), 32'd0);
    tick();
    check("both rd state", 32'(bus.state_interface_module), 32'd1);
    check("both rd addr", 32'(bus.mem_rd_addr), 32'h600);
    check("both rd req", 32'(bus.mem_rd_req), 32'd1);
    bus.mem_rd_finish = 1'b1;
    tick();
    bus.mem_rd_finish = 1'b0;
    check("both rd_end", 32'(bus.state_interface_module), 32'd3);
    tick();
    tick();
    check("both final idle", 32'(bus.state_interface_module), 32'd0);
    idle_inputs();

    // Read request held high: one burst only, re-arm after a low cycle.
    apply_reset();
    bus.DATA_read_addr = 28'h700;
    bus.DATA_read_req  = 1'b1;
    grants = 0;
    prev   = 4'd0;
    for (int c = 0; c < 40; c++) begin
      tick();
      cur = bus.state_interface_module;
      if (cur == 4'd1 && prev != 4'd1) grants++;
      prev = cur;
      bus.mem_rd_finish = (cur == 4'd1);
    end
    check("hold grants", 32'(grants), 32'd1);
    check("hold state", 32'(bus.state_interface_module), 32'd0);
    bus.DATA_read_req = 1'b0;
    bus.mem_rd_finish = 1'b0;
    tick();
    bus.DATA_read_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      cur = bus.state_interface_module;
      if (cur == 4'd1 && prev != 4'd1) grants++;
      prev = cur;
      bus.mem_rd_finish = (cur == 4'd1);
    end
    check("rearm grants", 32'(grants), 32'd2);
    idle_inputs();

    // Reset in the middle of a read burst.
    apply_reset();
    bus.DATA_read_addr = 28'h280;
    bus.DATA_read_req  = 1'b1;
    tick();
    tick();
    check("rstmid state", 32'(bus.state_interface_module), 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus.mem_rd_data  = 32'h2000 + 32'(i);
      bus.mem_rd_valid = 1'b1;
      tick();
    end
    check("rstmid cnt", 32'(bus.rd_cnt_data), 32'd5);
    check("rstmid valid", 32'(bus.rd_burst_data_valid), 32'd1);
    idle_inputs();
    rst = 1'b0;
    #1;
    check_all_zero("rstmid");
    tick();
    rst = 1'b1;
    tick();
    check("rstmid release state", 32'(bus.state_interface_module), 32'd0);
    tick();
    check("rstmid release state2", 32'(bus.state_interface_module), 32'd0);
    check("rstmid release rd_req", 32'(bus.mem_rd_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_interface.md
DATA_MEM_INTERFACE -- requirements
Module: data_mem_interface

Interface
REQ-001 SHALL have parameters: DATA_WIDTH 16, cache word width; DATA_CACHE_DEPTH 16, words per data burst; DDR_ADDR_WIDTH 28, byte address width; MEM_DATA_WIDTH 32, memory beat width.
REQ-002 SHALL have ports: clk in 1, the single clock; rst in 1, asynchronous active-low reset.
REQ-003 SHALL have these cache-side ports: DATA_read_req in 1; DATA_read_addr in DDR_ADDR_WIDTH; JMP_ADDR_read_req in 1; DATA_store_req in 1; DATA_write_addr in DDR_ADDR_WIDTH; DATA_to_ddr in DATA_WIDTH; data_to_ddr_rdy in 1.
REQ-004 SHALL have these cache-side outputs: DATA_to_cache out DATA_WIDTH; JMP_ADDR_to_cache out DDR_ADDR_WIDTH; rd_cnt_data out 10, read beat count; rd_burst_data_valid out 1; wr_burst_data_req out 1; state_interface_module out 4, current state.
REQ-005 SHALL have these memory-side read ports: mem_rd_req out 1; mem_rd_addr out DDR_ADDR_WIDTH; mem_rd_len out 10; mem_rd_data in MEM_DATA_WIDTH; mem_rd_valid in 1; mem_rd_finish in 1.
REQ-006 SHALL have these memory-side write ports: mem_wr_req out 1; mem_wr_addr out DDR_ADDR_WIDTH; mem_wr_len out 10; mem_wr_data out MEM_DATA_WIDTH; mem_wr_data_req in 1; mem_wr_finish in 1.

Function
REQ-007 SHALL encode states IDLE=0, MEM_READ_DATA=1, MEM_READ_JMP=2, MEM_READ_END=3, MEM_WRITE_DATA_STORE=9, MEM_WRITE_END=10, driven on state_interface_module.
REQ-008 SHALL arm each request on its rising edge and disarm it at burst start, so a request held high after completion does not start a second burst.
REQ-009 SHALL, in IDLE with several requests armed, grant them in priority order store, then data read, then jump read.
REQ-010 SHALL, at grant, latch the request address into mem_rd_addr or mem_wr_addr, and clear the beat counters in the same cycle.
REQ-011 SHALL, for a data read, set mem_rd_len = DATA_CACHE_DEPTH+1; the extra beat covers the cache's one-cycle capture delay.
REQ-012 SHALL, for a jump read, set mem_rd_len = 1.
REQ-013 SHALL hold mem_rd_req / mem_wr_req high from grant until mem_rd_finish / mem_wr_finish is sampled high.
REQ-014 SHALL, for read beat k (1-based) sampled with mem_rd_valid, drive the following in the next cycle:
  - rd_burst_data_valid=1;
  - DATA_to_cache = mem_rd_data[DATA_WIDTH-1:0];
  - rd_cnt_data=k;
  - in MEM_READ_JMP only, JMP_ADDR_to_cache = mem_rd_data[DDR_ADDR_WIDTH-1:0].
REQ-015 SHALL hold rd_cnt_data and JMP_ADDR_to_cache after a burst until the next grant.
REQ-016 SHALL saturate rd_cnt_data at mem_rd_len and ignore extra beats.
REQ-017 SHALL, in MEM_WRITE_DATA_STORE, drive wr_burst_data_req combinationally as mem_wr_data_req AND (write count < DATA_CACHE_DEPTH).
REQ-018 SHALL drive mem_wr_data = zero-extended DATA_to_ddr when data_to_ddr_rdy=1, else 0.
REQ-019 SHALL increment the write count on each cycle with wr_burst_data_req=1 and data_to_ddr_rdy=1, and set mem_wr_len = DATA_CACHE_DEPTH.
REQ-020 SHALL use these transitions:
  - read states go to MEM_READ_END on mem_rd_finish;
  - the write state goes to MEM_WRITE_END on mem_wr_finish;
  - each END state lasts exactly 1 cycle, then IDLE.
REQ-021 SHALL register rd_burst_data_valid and treat it as a 1-cycle pulse per beat; it is never high in IDLE or in the write states.
REQ-022 SHALL, if finish arrives before all beats, still end the burst; the counts keep their achieved values.

Reset
REQ-023 SHALL, on rst low, immediately force:
  - state IDLE;
  - all request outputs 0;
  - rd_cnt_data=0, rd_burst_data_valid=0, wr_burst_data_req=0;
  - DATA_to_cache=0, JMP_ADDR_to_cache=0;
  - addresses and lengths 0;
  - armed flags cleared.
REQ-024 SHALL abandon a burst interrupted by reset; the memory side is reset by the same rst.

Structure
REQ-025 SHALL place the state encodings (especially MEM_WRITE_DATA_STORE=9) and the cache-command constants in a shared package used by both the cache and this block.
REQ-026 SHALL instantiate one sub-module, req_edge_arm (rising-edge arm / grant-clear flag, three instances); everything else is flat.

Verification
REQ-027 SHALL check a data read with DATA_read_addr=0x280 and the memory returning words 0x1000..0x1010: mem_rd_len=17, 17 valid pulses, rd_cnt_data 1..17, last DATA_to_cache=0x1010, then END→IDLE.
REQ-028 SHALL check a jump read whose memory beat is 0x0ABCDEF: JMP_ADDR_to_cache=0xABCDEF and rd_cnt_data=1 with valid, one cycle after the beat.
REQ-029 SHALL check a store with DATA_write_addr=0x400, data_to_ddr_rdy=1, and 20 mem_wr_data_req pulses: exactly 16 wr_burst_data_req pulses, with state=9 throughout.
REQ-030 SHALL check store and read requests rising in the same cycle: the store is served first, then the read starts after MEM_WRITE_END→IDLE.
REQ-031 SHALL check DATA_read_req held high for 40 cycles: exactly one burst is issued; a second burst follows only after the request drops for 1 cycle and rises again.
REQ-032 SHALL check rst asserted at read beat 5: all outputs 0 in the same cycle, and state 0 on release.
